// File: rtl/acq_corr_sequencer_if.sv
// Control and datapath-side signals between the acquisition engine, the
// adder-tree match-bit source and the correlation segment sequencer.
interface acq_corr_sequencer_if #(
  parameter int SEG_W  = 2,
  parameter int ONES_W = 10,
  parameter int RES_W  = 11
);
  logic              start;
  logic [SEG_W-1:0]  seg_num;
  logic              abort;
  logic              busy;
  logic              tree_in_en;
  logic [SEG_W-1:0]  seg_sel;
  logic [8:0]        tree_out;
  logic              result_valid;
  logic [ONES_W-1:0] ones_cnt;
  logic [RES_W-1:0]  result;

  modport master (
    output start, seg_num, abort, tree_out,
    input  busy, tree_in_en, seg_sel, result_valid, ones_cnt, result
  );

  modport slave (
    input  start, seg_num, abort, tree_out,
    output busy, tree_in_en, seg_sel, result_valid, ones_cnt, result
  );
endinterface

// File: rtl/acq_corr_sequencer.sv
// Steps the shared 341-input adder tree over up to 3 segments and sums the
// partial ones counts into a total count and a bipolar correlation value.
//
// state | meaning
// IDLE  | waiting for a start with a legal segment count
// ISSUE | one segment select per cycle to the match-bit source
// DRAIN | two cycles for the last tree sums to come out of the pipeline
// DONE  | one-cycle result_valid pulse
module acq_corr_sequencer #(
  parameter int SEG_W    = 2,
  parameter int MAX_SEG  = 3,
  parameter int SEG_BITS = 341,
  parameter int ONES_W   = 10,
  parameter int RES_W    = 11
) (
  input logic clk,
  input logic rst_b,
  acq_corr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [SEG_W-1:0]  seg_n;
  logic [SEG_W-1:0]  seg_sel_r;
  logic              tree_en_r;
  logic              busy_r;
  logic              valid_r;
  logic              drain_cnt;
  logic              v0, v1;
  logic [ONES_W-1:0] acc;
  logic [ONES_W-1:0] acc_next;
  logic [RES_W-1:0]  res_r;
  logic [RES_W-1:0]  seg_total;
  logic              start_ok;

  assign start_ok  = bus.start && (bus.seg_num != '0) && (int'(bus.seg_num) <= MAX_SEG);
  assign acc_next  = v1 ? (acc + ONES_W'(bus.tree_out)) : acc;
  assign seg_total = RES_W'(SEG_BITS * int'(seg_n));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= S_IDLE;
      seg_n     <= '0;
      seg_sel_r <= '0;
      tree_en_r <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      drain_cnt <= 1'b0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      acc       <= '0;
      res_r     <= '0;
    end else begin
      v0      <= tree_en_r;
      v1      <= v0;
      acc     <= acc_next;
      valid_r <= 1'b0;
      if (bus.abort) begin
        // abort beats start and discards any sums still in flight
        state     <= S_IDLE;
        busy_r    <= 1'b0;
        tree_en_r <= 1'b0;
        seg_sel_r <= '0;
        drain_cnt <= 1'b0;
        v0        <= 1'b0;
        v1        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              seg_n     <= bus.seg_num;
              acc       <= '0;
              res_r     <= '0;
              seg_sel_r <= '0;
              tree_en_r <= 1'b1;
              busy_r    <= 1'b1;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (seg_sel_r == seg_n - 1'b1) begin
              tree_en_r <= 1'b0;
              seg_sel_r <= '0;
              drain_cnt <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              seg_sel_r <= seg_sel_r + 1'b1;
            end
          end
          S_DRAIN: begin
            drain_cnt <= 1'b1;
            if (drain_cnt) begin
              // last tree sum lands on this edge, so build the result from acc_next
              res_r   <= RES_W'({acc_next, 1'b0}) - seg_total;
              valid_r <= 1'b1;
              state   <= S_DONE;
            end
          end
          S_DONE: begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy         = busy_r;
  assign bus.tree_in_en   = tree_en_r;
  assign bus.seg_sel      = seg_sel_r;
  assign bus.result_valid = valid_r;
  assign bus.ones_cnt     = acc;
  assign bus.result       = res_r;

endmodule

// File: tb/tb_acq_corr_sequencer.sv
// Scoreboard bench for acq_corr_sequencer: directed runs push expected
// results, a negedge monitor pops and compares on every result_valid.
module tb_acq_corr_sequencer;

  logic clk = 1'b0;
  logic rst_b;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  typedef struct {
    int ones;
    int res;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   seg_vals[4];
  logic [8:0] stage1 = 9'd0;
  logic [8:0] stage2 = 9'd0;

  acq_corr_sequencer_if #(.SEG_W(2), .ONES_W(10), .RES_W(11)) bus ();

  acq_corr_sequencer dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle registered adder tree; junk outside valid slots exposes stray accumulation.
  always @(posedge clk) begin
    stage1 <= bus.tree_in_en ? 9'(seg_vals[bus.seg_sel]) : 9'd77;
    stage2 <= stage1;
  end
  assign bus.tree_out = stage2;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ones_cnt", int'(bus.ones_cnt), e.ones);
        check("result", int'($signed(bus.result)), e.res);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run(input int n, input int a, input int b, input int c,
                     input int e_ones, input int e_res, input bit noisy);
    exp_t e;
    int   t0;
    seg_vals[0] = a;
    seg_vals[1] = b;
    seg_vals[2] = c;
    seg_vals[3] = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.seg_num = n[1:0];
    t0 = cyc;
    e.ones = e_ones;
    e.res  = e_res;
    e.cyc  = t0 + n + 3;
    exp_q.push_back(e);
    @(negedge clk);
    check("start_busy", int'(bus.busy), 0);
    check("start_en", int'(bus.tree_in_en), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("issue_en", int'(bus.tree_in_en), 1);
      check("issue_sel", int'(bus.seg_sel), i);
      check("issue_busy", int'(bus.busy), 1);
      if (noisy) begin
        bus.start = 1'b1;
        bus.seg_num = 2'd1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_en", int'(bus.tree_in_en), 0);
      check("drain_sel", int'(bus.seg_sel), 0);
      check("drain_busy", int'(bus.busy), 1);
      if (noisy) begin
        bus.start = 1'b1;
        bus.seg_num = 2'd1;
      end
    end
    @(negedge clk);
    check("done_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    bus.seg_num = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.seg_num = 2'd0;
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) seg_vals[i] = 0;
    rst_b = 1'b1;
    #2 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_en", int'(bus.tree_in_en), 0);
    check("rst_sel", int'(bus.seg_sel), 0);
    check("rst_valid", int'(bus.result_valid), 0);
    check("rst_ones", int'(bus.ones_cnt), 0);
    check("rst_result", int'(bus.result), 0);
    rst_b = 1'b1;

    // Full-scale, mixed, all-zero, single segment then back-to-back two segments
    run(3, 341, 341, 341, 1023, 1023, 1'b0);
    run(3, 100, 200, 50, 350, -323, 1'b0);
    run(3, 0, 0, 0, 0, -1023, 1'b0);
    run(1, 200, 0, 0, 200, 59, 1'b0);
    run(2, 10, 20, 0, 30, -622, 1'b0);
    @(negedge clk);
    check("hold_ones", int'(bus.ones_cnt), 30);
    check("hold_result", int'($signed(bus.result)), -622);

    // Ignored starts: zero segment count, and abort in the same cycle
    @(posedge clk); #1;
    bus.start = 1'b1; bus.seg_num = 2'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("seg0_en", int'(bus.tree_in_en), 0);
    check("seg0_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.seg_num = 2'd3; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abstart_en", int'(bus.tree_in_en), 0);
    check("abstart_busy", int'(bus.busy), 0);

    // Abort in cycle 2 of a three-segment run
    seg_vals[0] = 341; seg_vals[1] = 341; seg_vals[2] = 341;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.seg_num = 2'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_en", int'(bus.tree_in_en), 0);
    repeat (8) @(negedge clk);
    run(3, 341, 341, 341, 1023, 1023, 1'b0);

    // Start pulses during ISSUE and DRAIN must not disturb the run
    run(2, 5, 300, 0, 305, -72, 1'b1);

    // Reset in the second DRAIN cycle of a two-segment run
    seg_vals[0] = 100; seg_vals[1] = 200;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.seg_num = 2'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_ones", int'(bus.ones_cnt), 100);
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst_b = 1'b0;
    #1;
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_ones", int'(bus.ones_cnt), 0);
    check("async_rst_en", int'(bus.tree_in_en), 0);
    check("async_rst_valid", int'(bus.result_valid), 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);

    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
